sprite_table: RTL

Parametrised sprite attribute store replacing the processor's fixed per-sprite register array. It holds up to MAX_SPRITES records of NUM_FIELDS fields each and tracks an alive mask. It allocates the lowest free slot in hardware and serves processor field reads and writes. A scan engine streams every alive sprite to the renderer over a valid/ready handshake. The block sits between the processor (alloc, free, read and write ports) and the pixel pipeline (scan port).

---
 rtl/sprite_table.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_table.sv
`default_nettype none
// ============================================================================
// Module      : sprite_table
// Description : Parametrised sprite attribute store. Holds MAX_SPRITES records
//               of NUM_FIELDS fields each plus an alive mask. Hardware
//               allocation of the lowest free slot, processor field
//               read/write, and a scan engine that streams every alive sprite
//               over a valid/ready handshake.
// Ports       : pixel_clk_in / rst_in       clock, synchronous active-high reset
//               alloc_*                     allocation request and response
//               free_*                      slot release
//               wr_* / rd_*                 field write, registered field read
//               count_out                   number of alive slots
//               scan_*                      scan pass control and beat output
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_table #(
    parameter  int MAX_SPRITES = 32,
    parameter  int NUM_FIELDS  = 4,
    parameter  int FIELD_WIDTH = 16,
    localparam int ID_W        = $clog2(MAX_SPRITES),
    localparam int FI_W        = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
    localparam int CNT_W       = $clog2(MAX_SPRITES + 1),
    localparam int REC_W       = NUM_FIELDS * FIELD_WIDTH
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   alloc_req_in,
    input  logic [REC_W-1:0]       alloc_fields_in,
    output logic                   alloc_ok_out,
    output logic                   alloc_fail_out,
    output logic [ID_W-1:0]        alloc_id_out,
    input  logic                   free_en_in,
    input  logic [ID_W-1:0]        free_id_in,
    input  logic                   wr_en_in,
    input  logic [ID_W-1:0]        wr_id_in,
    input  logic [FI_W-1:0]        wr_field_in,
    input  logic [FIELD_WIDTH-1:0] wr_data_in,
    input  logic [ID_W-1:0]        rd_id_in,
    input  logic [FI_W-1:0]        rd_field_in,
    output logic [FIELD_WIDTH-1:0] rd_data_out,
    output logic [CNT_W-1:0]       count_out,
    input  logic                   scan_start_in,
    output logic                   scan_valid_out,
    input  logic                   scan_ready_in,
    output logic [ID_W-1:0]        scan_id_out,
    output logic [REC_W-1:0]       scan_fields_out,
    output logic                   scan_busy_out,
    output logic                   scan_done_out
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_seek    = 2'd1;
    localparam logic [1:0] c_st_present = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    logic [MAX_SPRITES-1:0] r_alive;
    logic [FIELD_WIDTH-1:0] r_fields [MAX_SPRITES][NUM_FIELDS];
    logic [CNT_W-1:0]       r_count;
    logic                   r_alloc_ok;
    logic                   r_alloc_fail;
    logic [ID_W-1:0]        r_alloc_id;
    logic [FIELD_WIDTH-1:0] r_rd_data;
    logic [1:0]             r_state;
    logic [ID_W:0]          r_ptr;      // one bit wider so it can point past the last slot
    logic [ID_W-1:0]        r_scan_id;
    logic [REC_W-1:0]       r_scan_fields;

    logic                   w_grant_found;
    logic [ID_W-1:0]        w_grant_id;
    logic                   w_grant;
    logic                   w_free_hit;
    logic                   w_wr_hit;
    logic [MAX_SPRITES-1:0] w_alive_next;
    logic [FIELD_WIDTH-1:0] w_rd_data;
    logic                   w_seek_found;
    logic [ID_W-1:0]        w_seek_id;
    logic [REC_W-1:0]       w_seek_rec;
    logic [1:0]             w_state_next;
    logic                   w_scan_valid;
    logic                   w_scan_busy;
    logic                   w_scan_done;

    // Lowest dead slot, taken from the mask before this cycle's free so a
    // slot released this cycle is never handed out in the same cycle.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
            if (!r_alive[i]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(i);
            end
        end
    end

    assign w_grant    = alloc_req_in && w_grant_found;
    assign w_free_hit = free_en_in && (int'(free_id_in) < MAX_SPRITES) && r_alive[free_id_in];
    assign w_wr_hit   = wr_en_in && (int'(wr_id_in) < MAX_SPRITES) && (int'(wr_field_in) < NUM_FIELDS)
                        && r_alive[wr_id_in] && !(w_free_hit && (free_id_in == wr_id_in));

    // Granted slot is dead and freed slot is alive, so the two never collide.
    always_comb begin
        w_alive_next = r_alive;
        if (w_grant)    w_alive_next[w_grant_id] = 1'b1;
        if (w_free_hit) w_alive_next[free_id_in] = 1'b0;
    end

    always_comb begin
        w_rd_data = '0;
        if ((int'(rd_id_in) < MAX_SPRITES) && (int'(rd_field_in) < NUM_FIELDS) && r_alive[rd_id_in])
            w_rd_data = r_fields[rd_id_in][rd_field_in];
    end

    // Field storage is deliberately not reset.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            if (w_grant) begin
                for (int f = 0; f < NUM_FIELDS; f++)
                    r_fields[w_grant_id][f] <= alloc_fields_in[f*FIELD_WIDTH +: FIELD_WIDTH];
            end
            if (w_wr_hit)
                r_fields[wr_id_in][wr_field_in] <= wr_data_in;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_alive      <= '0;
            r_count      <= '0;
            r_alloc_ok   <= 1'b0;
            r_alloc_fail <= 1'b0;
            r_alloc_id   <= '0;
            r_rd_data    <= '0;
        end else begin
            r_alive      <= w_alive_next;
            r_count      <= r_count + CNT_W'(w_grant) - CNT_W'(w_free_hit);
            r_alloc_ok   <= w_grant;
            r_alloc_fail <= alloc_req_in && !w_grant_found;
            if (w_grant)
                r_alloc_id <= w_grant_id;
            r_rd_data    <= w_rd_data;
        end
    end

    // Lowest alive slot at or above the scan pointer, against the live mask.
    always_comb begin
        w_seek_found = 1'b0;
        w_seek_id    = '0;
        for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
            if (r_alive[i] && (i >= int'(r_ptr))) begin
                w_seek_found = 1'b1;
                w_seek_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_seek_rec = '0;
        for (int f = 0; f < NUM_FIELDS; f++)
            w_seek_rec[f*FIELD_WIDTH +: FIELD_WIDTH] = r_fields[w_seek_id][f];
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (scan_start_in) w_state_next = c_st_seek;
            c_st_seek:    w_state_next = w_seek_found ? c_st_present : c_st_done;
            c_st_present: if (scan_ready_in) w_state_next = c_st_seek;
            c_st_done:    w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_scan_valid = (r_state == c_st_present);
        w_scan_busy  = (r_state != c_st_idle);
        w_scan_done  = (r_state == c_st_done);
    end

    // Beat snapshot is captured in SEEK so later writes cannot disturb a held beat.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_ptr         <= '0;
            r_scan_id     <= '0;
            r_scan_fields <= '0;
        end else begin
            if ((r_state == c_st_idle) && scan_start_in)
                r_ptr <= '0;
            if ((r_state == c_st_seek) && w_seek_found) begin
                r_scan_id     <= w_seek_id;
                r_scan_fields <= w_seek_rec;
                r_ptr         <= {1'b0, w_seek_id} + (ID_W+1)'(1);
            end
        end
    end

    assign alloc_ok_out    = r_alloc_ok;
    assign alloc_fail_out  = r_alloc_fail;
    assign alloc_id_out    = r_alloc_id;
    assign rd_data_out     = r_rd_data;
    assign count_out       = r_count;
    assign scan_valid_out  = w_scan_valid;
    assign scan_id_out     = r_scan_id;
    assign scan_fields_out = r_scan_fields;
    assign scan_busy_out   = w_scan_busy;
    assign scan_done_out   = w_scan_done;

endmodule
`default_nettype wire
